// File: rtl/image_mem_pingpong_ctrl_if.sv
// image_mem_pingpong_ctrl_if: tile-source, RAM-control and consumer signals of the ping-pong sequencer.
interface image_mem_pingpong_ctrl_if #(parameter int ADDR_WIDTH = 13);
   logic [ADDR_WIDTH-1:0] cfg_num_tiles;
   logic                  in_valid;
   logic                  in_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_write_address;
   logic [ADDR_WIDTH-1:0] mem_read_address;
   logic                  rd_ready;
   logic                  out_valid;
   logic                  out_last;
   logic                  out_buf;
   logic [1:0]            buf_full;
   logic                  frame_done;
   modport master (
      output cfg_num_tiles, in_valid, rd_ready,
      input  in_ready, mem_we, mem_write_address, mem_read_address,
             out_valid, out_last, out_buf, buf_full, frame_done
   );
   modport slave (
      input  cfg_num_tiles, in_valid, rd_ready,
      output in_ready, mem_we, mem_write_address, mem_read_address,
             out_valid, out_last, out_buf, buf_full, frame_done
   );
endinterface

// File: rtl/image_mem_pingpong_ctrl.sv
// image_mem_pingpong_ctrl: fills one half of the tile memory while the other half drains to the FFT path.
module image_mem_pingpong_ctrl #(
   parameter int ADDR_WIDTH = 13
) (
   input  logic clk,
   input  logic reset,
   image_mem_pingpong_ctrl_if.slave bus
);
   localparam int CW = ADDR_WIDTH - 1;
   localparam logic [ADDR_WIDTH-1:0] DEPTH = {1'b1, {CW{1'b0}}};
   localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
   // bit 1 of the half state marks "holds a complete frame"
   localparam logic [1:0] EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2, DRAINING = 2'd3;
   logic [1:0][1:0]            st_q, st_d;
   logic [1:0][ADDR_WIDTH-1:0] len_q, len_d;
   logic                       wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
   logic [CW-1:0]              wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
   logic                       out_valid_q, out_last_q, out_buf_q, frame_done_q;
   logic [ADDR_WIDTH-1:0]      sat_len, wr_len;
   logic                       wr_open, wr_acc, wr_last, rd_iss, rd_last;

   assign sat_len = (bus.cfg_num_tiles == '0 || bus.cfg_num_tiles > DEPTH) ? DEPTH : bus.cfg_num_tiles;
   assign wr_open = st_q[wr_sel_q] == EMPTY || st_q[wr_sel_q] == FILLING;
   assign wr_acc  = bus.in_valid & wr_open & ~reset;
   assign wr_len  = st_q[wr_sel_q] == EMPTY ? sat_len : len_q[wr_sel_q];
   assign wr_last = wr_acc && {1'b0, wr_cnt_q} == wr_len - ONE;
   assign rd_iss  = bus.rd_ready && (st_q[rd_sel_q] == FULL || st_q[rd_sel_q] == DRAINING);
   assign rd_last = rd_iss && {1'b0, rd_cnt_q} == len_q[rd_sel_q] - ONE;

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q         <= '0;
         len_q        <= '0;
         wr_sel_q     <= 1'b0;
         rd_sel_q     <= 1'b0;
         wr_cnt_q     <= '0;
         rd_cnt_q     <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_buf_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         st_q         <= st_d;
         len_q        <= len_d;
         wr_sel_q     <= wr_sel_d;
         rd_sel_q     <= rd_sel_d;
         wr_cnt_q     <= wr_cnt_d;
         rd_cnt_q     <= rd_cnt_d;
         out_valid_q  <= rd_iss;
         out_last_q   <= rd_last;
         out_buf_q    <= rd_sel_q;
         frame_done_q <= rd_last;
      end
   end

   // writes and reads always target different halves, so both updates can apply in one cycle
   always_comb begin
      st_d     = st_q;
      len_d    = len_q;
      wr_sel_d = wr_sel_q;
      rd_sel_d = rd_sel_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      if (wr_acc) begin
         len_d[wr_sel_q] = wr_len;
         st_d[wr_sel_q]  = wr_last ? FULL : FILLING;
         wr_cnt_d        = wr_last ? '0 : wr_cnt_q + CW'(1);
         wr_sel_d        = wr_sel_q ^ wr_last;
      end
      if (rd_iss) begin
         st_d[rd_sel_q] = rd_last ? EMPTY : DRAINING;
         rd_cnt_d       = rd_last ? '0 : rd_cnt_q + CW'(1);
         rd_sel_d       = rd_sel_q ^ rd_last;
      end
   end

   always_comb begin
      bus.in_ready          = wr_open & ~reset;
      bus.mem_we            = wr_acc;
      bus.mem_write_address = {wr_sel_q, wr_cnt_q};
      bus.mem_read_address  = {rd_sel_q, rd_cnt_q};
      bus.buf_full          = {st_q[1][1], st_q[0][1]};
      bus.out_valid         = out_valid_q;
      bus.out_last          = out_last_q;
      bus.out_buf           = out_buf_q;
      bus.frame_done        = frame_done_q;
   end
endmodule

// File: tb/tb_image_mem_pingpong_ctrl.sv
// tb_image_mem_pingpong_ctrl: directed and random traffic checked against a frame-queue model of the ping-pong memory.
module tb_image_mem_pingpong_ctrl;
   logic clk = 1'b0;
   logic reset;
   int   pass = 0, total = 0;
   // frames resident in memory, oldest first: half, length, tiles written, tiles issued for read
   int   fh[$], fl[$], fw[$], fr[$];
   int   nh;
   logic ev, el, eb, ef;

   image_mem_pingpong_ctrl_if bus ();
   image_mem_pingpong_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));

   always #5 clk = ~clk;

   function automatic int sat(input int c);
      return (c == 0 || c > 4096) ? 4096 : c;
   endfunction

   task automatic cyc(input logic v, input logic r, input int cfg, input logic rst);
      int n, ewa, era, er;
      logic ew, iss, elast, tail_open, hb;
      logic [1:0] ebf;
      reset = rst;
      bus.in_valid = v;
      bus.rd_ready = r;
      bus.cfg_num_tiles = 13'(cfg);
      #2;
      total++;
      if (bus.out_valid !== ev) $display("FAIL out_valid: got %b expected %b", bus.out_valid, ev); else pass++;
      total++;
      if (bus.frame_done !== ef) $display("FAIL frame_done: got %b expected %b", bus.frame_done, ef); else pass++;
      if (ev) begin
         total++;
         if (bus.out_last !== el) $display("FAIL out_last: got %b expected %b", bus.out_last, el); else pass++;
         total++;
         if (bus.out_buf !== eb) $display("FAIL out_buf: got %b expected %b", bus.out_buf, eb); else pass++;
      end
      n = fh.size();
      tail_open = n > 0 && fw[n-1] < fl[n-1];
      if (rst) begin
         total++;
         if (bus.in_ready !== 1'b0) $display("FAIL in_ready_rst: got %b expected 0", bus.in_ready); else pass++;
         total++;
         if (bus.mem_we !== 1'b0) $display("FAIL mem_we_rst: got %b expected 0", bus.mem_we); else pass++;
         fh.delete(); fl.delete(); fw.delete(); fr.delete();
         nh = 0; ev = 0; el = 0; eb = 0; ef = 0;
      end else begin
         er = (tail_open || n < 2) ? 1 : 0;
         ew = v && er != 0;
         total++;
         if (bus.in_ready !== (er != 0)) $display("FAIL in_ready: got %b expected %0d", bus.in_ready, er); else pass++;
         total++;
         if (bus.mem_we !== ew) $display("FAIL mem_we: got %b expected %b", bus.mem_we, ew); else pass++;
         ebf = 2'b00;
         for (int i = 0; i < n; i++) if (fw[i] == fl[i]) ebf[fh[i]] = 1'b1;
         total++;
         if (bus.buf_full !== ebf) $display("FAIL buf_full: got %b expected %b", bus.buf_full, ebf); else pass++;
         if (ew) begin
            ewa = tail_open ? fh[n-1] * 4096 + fw[n-1] : nh * 4096;
            total++;
            if (bus.mem_write_address !== 13'(ewa)) $display("FAIL wr_addr: got %0d expected %0d", bus.mem_write_address, ewa); else pass++;
         end
         iss = r && n > 0 && fw[0] == fl[0];
         elast = 1'b0;
         hb = 1'b0;
         if (iss) begin
            era = fh[0] * 4096 + fr[0];
            total++;
            if (bus.mem_read_address !== 13'(era)) $display("FAIL rd_addr: got %0d expected %0d", bus.mem_read_address, era); else pass++;
            elast = fr[0] == fl[0] - 1;
            hb = fh[0][0];
         end
         if (ew) begin
            if (tail_open) fw[n-1] = fw[n-1] + 1;
            else begin
               fh.push_back(nh); fl.push_back(sat(cfg)); fw.push_back(1); fr.push_back(0);
               nh ^= 1;
            end
         end
         if (iss) begin
            fr[0] = fr[0] + 1;
            if (fr[0] == fl[0]) begin
               void'(fh.pop_front()); void'(fl.pop_front()); void'(fw.pop_front()); void'(fr.pop_front());
            end
         end
         ev = iss; el = iss && elast; eb = hb; ef = iss && elast;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      cyc(1, 1, 4, 1);
      cyc(1, 1, 4, 1);
      total++;
      if (bus.buf_full !== 2'b00) $display("FAIL reset_buf_full: got %b expected 00", bus.buf_full); else pass++;
   endtask

   task automatic test_fill_drain();
      cyc(0, 0, 4, 1);
      repeat (8) cyc(1, 0, 4, 0);
      cyc(1, 0, 4, 0);
      total++;
      if (bus.buf_full !== 2'b11) $display("FAIL both_full: got %b expected 11", bus.buf_full); else pass++;
      total++;
      if (bus.in_ready !== 1'b0) $display("FAIL both_full_ready: got %b expected 0", bus.in_ready); else pass++;
      repeat (12) cyc(0, 1, 4, 0);
   endtask

   task automatic test_single();
      cyc(0, 0, 1, 1);
      repeat (30) cyc(1, 1, 1, 0);
      repeat (4) cyc(0, 1, 1, 0);
   endtask

   task automatic test_saturate(input int cfg);
      cyc(0, 0, cfg, 1);
      repeat (8300) cyc(1, 1, cfg, 0);
   endtask

   task automatic test_midchange();
      cyc(0, 0, 8, 1);
      cyc(1, 0, 8, 0);
      repeat (7) cyc(1, 0, 2, 0);
      repeat (3) cyc(1, 0, 2, 0);
      total++;
      if (bus.buf_full !== 2'b11) $display("FAIL mid_full: got %b expected 11", bus.buf_full); else pass++;
      repeat (12) cyc(0, 1, 2, 0);
   endtask

   task automatic test_reset_drain();
      cyc(0, 0, 8, 1);
      repeat (16) cyc(1, 0, 8, 0);
      repeat (5) cyc(0, 1, 8, 0);
      cyc(0, 1, 8, 1);
      total++;
      if (bus.out_valid !== 1'b0) $display("FAIL rst_drain_valid: got %b expected 0", bus.out_valid); else pass++;
      total++;
      if (bus.buf_full !== 2'b00) $display("FAIL rst_drain_full: got %b expected 00", bus.buf_full); else pass++;
      reset = 1'b0;
      #1;
      total++;
      if (bus.in_ready !== 1'b1) $display("FAIL rst_drain_ready: got %b expected 1", bus.in_ready); else pass++;
      cyc(1, 0, 3, 0);
      repeat (6) cyc(1, 1, 3, 0);
   endtask

   task automatic test_random();
      cyc(0, 0, 3, 1);
      repeat (3000) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, int'($urandom_range(0, 9)), $urandom_range(0, 499) == 0);
   endtask

   initial begin
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.rd_ready = 1'b0;
      bus.cfg_num_tiles = '0;
      nh = 0; ev = 0; el = 0; eb = 0; ef = 0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_fill_drain();
      test_single();
      test_saturate(0);
      test_saturate(5000);
      test_midchange();
      test_reset_drain();
      test_random();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
